// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and frame layout helpers used by the transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RTS       = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } tx_state_t;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] ACK_BYTE    = 8'hFA;
  localparam logic [7:0] RESEND      = 8'hFE;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  // Bits the host shifts out after the start bit: {stop, odd parity, data}.
  function automatic logic [FRAME_LEN-2:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_filtro_flanco.sv
// PS/2 clock deglitcher and falling-edge detector. Shared with the receiver.
module ps2_filtro_flanco #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2clk,
  output logic o_ps2clk_f,
  output logic o_fall_tick
);

  logic [FILTER_LEN-1:0] r_muestras;
  logic                  r_filtrado;
  logic                  r_fall_tick;

  // Filtered level only changes when the whole window agrees; idle line is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_muestras  <= '1;
      r_filtrado  <= 1'b1;
      r_fall_tick <= 1'b0;
    end else begin
      r_muestras <= {r_muestras[FILTER_LEN-2:0], i_ps2clk};
      if (&r_muestras) begin
        r_filtrado  <= 1'b1;
        r_fall_tick <= 1'b0;
      end else if (~|r_muestras) begin
        r_filtrado  <= 1'b0;
        r_fall_tick <= r_filtrado;
      end else begin
        r_fall_tick <= 1'b0;
      end
    end
  end

  assign o_ps2clk_f  = r_filtrado;
  assign o_fall_tick = r_fall_tick;

endmodule

// File: rtl/transmisor_teclado_ps2.sv
// Host-to-device PS/2 transmitter: request-to-send, start, 8 data bits LSB
// first, odd parity, stop, then device acknowledge check, with a watchdog.
module transmisor_teclado_ps2
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = 10000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int RTS_W = $clog2(RTS_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(RTS_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  tx_state_t            r_state;
  logic [FRAME_LEN-2:0] r_frame;
  logic [3:0]           r_bit_cnt;
  logic [RTS_W-1:0]     r_rts_cnt;
  logic [WD_W-1:0]      r_wd_cnt;
  logic                 r_ps2clk_oe;
  logic                 r_ps2data_oe;
  logic                 r_tx_idle;
  logic                 r_tx_done_tick;
  logic                 r_tx_err;

  logic w_ps2clk_f;
  logic w_fall_tick;
  logic w_vigilancia;
  logic w_timeout;

  ps2_filtro_flanco #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filtro (
    .clk         (clk),
    .reset       (reset),
    .i_ps2clk    (ps2clk_in),
    .o_ps2clk_f  (w_ps2clk_f),
    .o_fall_tick (w_fall_tick)
  );

  assign w_vigilancia = (r_state == ST_START) || (r_state == ST_DATA) ||
                        (r_state == ST_ACK)   || (r_state == ST_WAIT_IDLE);
  assign w_timeout    = w_vigilancia && (r_wd_cnt == WD_LAST);

  // Transfer sequencer; outputs are updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_frame        <= '0;
      r_bit_cnt      <= 4'd0;
      r_rts_cnt      <= '0;
      r_wd_cnt       <= '0;
      r_ps2clk_oe    <= 1'b0;
      r_ps2data_oe   <= 1'b0;
      r_tx_idle      <= 1'b1;
      r_tx_done_tick <= 1'b0;
      r_tx_err       <= 1'b0;
    end else begin
      r_tx_done_tick <= 1'b0;
      if (w_timeout) begin
        r_ps2clk_oe    <= 1'b0;
        r_ps2data_oe   <= 1'b0;
        r_tx_err       <= 1'b1;
        r_tx_done_tick <= 1'b1;
        r_tx_idle      <= 1'b1;
        r_state        <= ST_IDLE;
      end else begin
        if (w_vigilancia) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
        end
        case (r_state)
          ST_IDLE: begin
            if (wr_ps2) begin
              r_frame     <= build_frame(din);
              r_tx_err    <= 1'b0;
              r_rts_cnt   <= RTS_LAST;
              r_ps2clk_oe <= 1'b1;
              r_tx_idle   <= 1'b0;
              r_state     <= ST_RTS;
            end
          end
          ST_RTS: begin
            if (r_rts_cnt == '0) begin
              r_ps2clk_oe  <= 1'b0;
              r_ps2data_oe <= 1'b1;
              r_wd_cnt     <= '0;
              r_state      <= ST_START;
            end else begin
              r_rts_cnt <= r_rts_cnt - 1'b1;
            end
          end
          ST_START: begin
            if (w_fall_tick) begin
              r_ps2data_oe <= ~r_frame[0];
              r_bit_cnt    <= 4'd0;
              r_state      <= ST_DATA;
            end
          end
          ST_DATA: begin
            // r_frame[1] is always the next bit to present; fall 10 releases data
            if (w_fall_tick) begin
              r_frame <= {1'b1, r_frame[FRAME_LEN-2:1]};
              if (r_bit_cnt == 4'd8) begin
                r_ps2data_oe <= 1'b0;
                r_state      <= ST_ACK;
              end else begin
                r_ps2data_oe <= ~r_frame[1];
                r_bit_cnt    <= r_bit_cnt + 1'b1;
              end
            end
          end
          ST_ACK: begin
            if (w_fall_tick) begin
              if (ps2data_in) begin
                r_tx_err <= 1'b1;
              end
              r_state <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (w_ps2clk_f && ps2data_in) begin
              r_tx_done_tick <= 1'b1;
              r_tx_idle      <= 1'b1;
              r_state        <= ST_IDLE;
            end
          end
          default: begin
            r_ps2clk_oe  <= 1'b0;
            r_ps2data_oe <= 1'b0;
            r_tx_idle    <= 1'b1;
            r_state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ps2clk_oe    = r_ps2clk_oe;
  assign ps2data_oe   = r_ps2data_oe;
  assign tx_idle      = r_tx_idle;
  assign tx_done_tick = r_tx_done_tick;
  assign tx_err       = r_tx_err;

endmodule

// File: tb/tb_transmisor_teclado_ps2.sv
// Scoreboard bench for transmisor_teclado_ps2 with a behavioural PS/2 device.
module tb_transmisor_teclado_ps2;
  import ps2_pkg::*;

  localparam int RTS  = 100;
  localparam int TO   = 5000;
  localparam int HALF = 40;

  typedef struct {
    logic [7:0] b;
    logic       par;
    logic       err;
    logic       chk_frame;
    logic       chk_lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2clk_in, ps2data_in;
  logic       ps2clk_oe, ps2data_oe, tx_idle, tx_done_tick, tx_err;

  exp_t       sb[$];
  exp_t       e;
  logic [9:0] cap;
  logic       cap_start;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         t_start = 0;
  int         done_cnt = 0;
  logic       prev_clk_oe = 1'b0;

  assign ps2clk_in  = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_in = ~(ps2data_oe | dev_data_low);

  transmisor_teclado_ps2 #(
    .RTS_CYCLES     (RTS),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2clk_in    (ps2clk_in),
    .ps2data_in   (ps2data_in),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2clk_oe    (ps2clk_oe),
    .ps2data_oe   (ps2data_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err       (tx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per tx_done_tick.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_clk_oe && !ps2clk_oe) t_start = cyc;
      if (tx_done_tick) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_err", tx_err, e.err);
          chk("done_idle", tx_idle, 1);
          chk("done_oe", {ps2clk_oe, ps2data_oe}, 0);
          if (e.chk_frame) begin
            chk("start_bit", cap_start, 0);
            chk("frame_bits", cap, {1'b1, e.par, e.b});
          end
          if (e.chk_lat) chk("timeout_latency", cyc - t_start, TO);
        end
      end
    end
    prev_clk_oe = ps2clk_oe;
  end

  task automatic send(input logic [7:0] b, input logic par, input logic err,
                      input logic chk_frame, input logic chk_lat);
    exp_t x;
    @(negedge clk);
    x.b = b; x.par = par; x.err = err; x.chk_frame = chk_frame; x.chk_lat = chk_lat;
    sb.push_back(x);
    din = b;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din = 8'h00;
    chk("wr_latency_clk_oe", ps2clk_oe, 1);
    chk("wr_busy", tx_idle, 0);
    chk("wr_err_clear", tx_err, 0);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!tx_idle && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (!tx_idle) chk("idle_timeout", 0, 1);
    repeat (20) @(negedge clk);
  endtask

  // Device: waits for RTS, clocks nbits, samples on rising edge, optional ack.
  task automatic device_run(input int nbits, input logic ack_low, input int glitch_bit);
    int w = 0;
    cap = 10'h3FF;
    cap_start = 1'b1;
    while (!ps2clk_oe && w < 2000) begin @(negedge clk); w++; end
    w = 0;
    while (ps2clk_oe && w < 2000) begin @(negedge clk); w++; end
    if (ps2clk_oe) begin
      chk("rts_release", 0, 1);
      return;
    end
    repeat (20) @(negedge clk);
    cap_start = ps2data_in;
    for (int i = 0; i < nbits && i < 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      cap[i] = ps2data_in;
      repeat (HALF) @(negedge clk);
      if (i == glitch_bit) begin
        dev_clk_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
    if (nbits > 10) begin
      dev_data_low = ack_low;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_clk_oe", ps2clk_oe, 0);
    chk("rst_data_oe", ps2data_oe, 0);
    chk("rst_idle", tx_idle, 1);
    chk("rst_done", tx_done_tick, 0);
    chk("rst_err", tx_err, 0);
    // wr_ps2 coinciding with the last reset edge must be dropped
    wr_ps2 = 1'b1;
    din = CMD_RESET;
    @(negedge clk);
    reset = 1'b0;
    wr_ps2 = 1'b0;
    @(negedge clk);
    chk("wr_at_reset_ignored", {ps2clk_oe, tx_idle}, 2'b01);
    repeat (5) @(negedge clk);

    // 1: set-LED command, ack ok
    fork
      device_run(11, 1'b1, -1);
      send(8'hED, 1'b1, 1'b0, 1'b1, 1'b0);
    join
    wait_idle();
    // 2: parity boundaries
    fork
      device_run(11, 1'b1, -1);
      send(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    join
    wait_idle();
    fork
      device_run(11, 1'b1, -1);
      send(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    join
    wait_idle();
    // 3: silent device -> watchdog
    send(8'hF4, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle();
    // 4: no ack
    fork
      device_run(11, 1'b0, -1);
      send(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
    join
    wait_idle();
    // 5: ignored second write plus short clock glitch
    fork
      device_run(11, 1'b1, 3);
      begin
        send(8'hED, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (300) @(negedge clk);
        din = 8'hF4;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din = 8'h00;
        chk("second_wr_busy", tx_idle, 0);
      end
    join
    wait_idle();
    // 6: reset in the middle of the data bits
    fork
      device_run(4, 1'b1, -1);
      send(8'hED, 1'b1, 1'b0, 1'b0, 1'b0);
    join
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_clk_oe", ps2clk_oe, 0);
    chk("midrst_data_oe", ps2data_oe, 0);
    chk("midrst_idle", tx_idle, 1);
    chk("midrst_done", tx_done_tick, 0);
    sb.delete();
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst_still_idle", tx_idle, 1);

    chk("done_tick_count", done_cnt, 6);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/transmisor_teclado_ps2.md
Name: transmisor_teclado_ps2

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable).
- Generates request-to-send, start bit, 8 data bits LSB first, odd parity and stop bit, then checks the device acknowledge.
- Drives the open-drain PS/2 lines through active-high pull-low enables.
- Sits beside the PS/2 receiver; `tx_idle` gates the receiver's `rx_en` so it ignores frames this block generates.

Parameters:
- RTS_CYCLES, 10000, clk cycles that ps2clk is held low for request-to-send (100 us at 100 MHz).
- FILTER_LEN, 8, length of the ps2clk sample filter, in samples.
- TIMEOUT_CYCLES, 2000000, watchdog limit per transfer after RTS (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ps2clk_in  in  1  sampled PS/2 clock line.
- ps2data_in  in  1  sampled PS/2 data line.
- wr_ps2  in  1  start-transfer strobe, one cycle.
- din  in  8  command byte.
- ps2clk_oe  out  1  1 = pull ps2clk low.
- ps2data_oe  out  1  1 = pull ps2data low.
- tx_idle  out  1  1 = no transfer in progress.
- tx_done_tick  out  1  one-cycle pulse at the end of a transfer.
- tx_err  out  1  result of the last transfer (ack missing or timeout); held until the next wr_ps2.

Behaviour:
- Reset: state idle, both oe=0, tx_idle=1, tx_done_tick=0, tx_err=0, all counters 0.
  - Reset mid-transfer releases both lines on the next clk edge.
- ps2clk filter:
  - Shift register of FILTER_LEN samples.
  - Filtered value becomes 1 when all samples are 1, 0 when all are 0, otherwise holds.
  - fall_tick = one-cycle pulse on a filtered 1->0 transition.
- Frame register, 10 bits: {stop=1, parity=~^din, din}. Data is shifted out LSB first.
- State idle:
  - tx_idle=1, both oe=0.
  - On wr_ps2: latch the frame, clear tx_err, load the RTS counter → rts.
- State rts:
  - ps2clk_oe=1, ps2data_oe=0.
  - After exactly RTS_CYCLES cycles → start, with the watchdog cleared.
- State start:
  - ps2clk_oe=0, ps2data_oe=1 (start bit 0).
  - On fall_tick: present frame bit 0, bit counter=0 → data.
- State data:
  - ps2data_oe = ~current frame bit.
  - Each fall_tick advances to the next frame bit.
  - Fall 9 presents parity. Fall 10 presents stop, i.e. data released.
  - On fall 10 → ack.
- State ack:
  - ps2data_oe=0.
  - On the next fall_tick: if ps2data_in is 0, ack is ok; otherwise set tx_err=1. Then → wait_idle.
- State wait_idle:
  - Waits until filtered ps2clk=1 and ps2data_in=1 on the same cycle.
  - Then pulses tx_done_tick for 1 cycle → idle.
- Watchdog:
  - Counts every cycle in start, data, ack and wait_idle.
  - On reaching TIMEOUT_CYCLES: release both lines, tx_err=1, pulse tx_done_tick → idle.
- tx_idle=0 in every state except idle.
- wr_ps2 while not idle is ignored; din is not re-latched.
- wr_ps2 on the same cycle as the reset deassertion edge is ignored.
- A glitch on ps2clk shorter than FILTER_LEN cycles produces no fall_tick.
- All outputs are registered. Latency from wr_ps2 to ps2clk_oe=1 is 1 clk.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding constants;
  - PS/2 command constants: CMD_SET_LED=0xED, CMD_RESET=0xFF, CMD_ENABLE=0xF4, ACK_BYTE=0xFA, RESEND=0xFE;
  - frame length 11.
- One sub-module, ps2_filtro_flanco: the ps2clk filter plus falling-edge detector. It is reused by the receiver.

Test Plan:
Sim parameters: RTS_CYCLES=100, TIMEOUT_CYCLES=5000. The device model clocks at a 50 us period, scaled down.
1. wr_ps2 with din=0xED; device samples each bit on the rising edge and drives ack=0 → device sees 0,1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done_tick once; tx_err=0; tx_idle returns to 1.
2. din=0x00 → parity bit 1. din=0x01 → parity bit 0. Data line held low for all 8 data bits of 0x00.
3. Device never clocks after RTS → tx_done_tick exactly 5000 cycles after entering start; tx_err=1; both oe=0.
4. Device leaves data high on the ack clock → tx_err=1, tx_done_tick=1.
5. Second wr_ps2 (din=0xF4) mid-transfer → ignored; the transmitted byte is still 0xED. 2-cycle ps2clk glitch → no extra bit shifted.
6. reset asserted during data state → ps2clk_oe=0, ps2data_oe=0, tx_idle=1 on the next cycle; no tx_done_tick.
